// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and status-bit definitions for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NEG  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_PASS = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

  localparam int unsigned STAT_V = 3;
  localparam int unsigned STAT_C = 2;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_Z = 0;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations and {V,C,N,Z} generation; MUL is handled by the pipe.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output logic             illegal
);

  localparam int WP1 = WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;
  logic [SHW-1:0]   sh;

  assign sh = b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wide    = '0;
    r       = '0;
    c       = 1'b0;
    v       = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + WP1'(cin);
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} + {1'b0, ~b} + WP1'(1);
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NEG: begin
        r = '0 - a;
        c = (a == '0);
        v = (a == MIN_INT);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      // The extra bit beside the operand catches the last bit shifted out.
      OP_SHL: begin
        wide = {1'b0, a} << sh;
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      OP_SHR: begin
        wide = {a, 1'b0} >> sh;
        r    = wide[WIDTH:1];
        c    = wide[0];
      end
      OP_SRA: begin
        wide = unsigned'($signed({a, 1'b0}) >>> sh);
        r    = wide[WIDTH:1];
        c    = wide[0];
      end
      OP_MUL: r = '0;
      default: illegal = 1'b1;
    endcase
  end

  assign result = r;

  always_comb begin
    status         = '0;
    status[STAT_V] = v;
    status[STAT_C] = c;
    status[STAT_N] = r[WIDTH-1];
    status[STAT_Z] = (r == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops via alu_comb, shift-add multiply FSM, output and sticky flags registers.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output logic [3:0]       flags,
  output logic             illegal,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               setf_q, setf_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         status_q, status_d;
  logic [3:0]         flags_q, flags_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0] comb_result;
  logic [3:0]       comb_status;
  logic             comb_illegal;
  logic [3:0]       mul_status;
  logic             accept;
  logic             out_free;

  alu_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
    .op      (op),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .result  (comb_result),
    .status  (comb_status),
    .illegal (comb_illegal)
  );

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    mul_status         = '0;
    mul_status[STAT_V] = |acc_q[2*WIDTH-1:WIDTH];
    mul_status[STAT_N] = acc_q[WIDTH-1];
    mul_status[STAT_Z] = (acc_q[WIDTH-1:0] == '0);
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    setf_d      = setf_q;
    result_d    = result_q;
    status_d    = status_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = ST_MUL;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            setf_d   = set_flags;
          end else begin
            result_d    = comb_result;
            status_d    = comb_status;
            illegal_d   = comb_illegal;
            out_valid_d = 1'b1;
            if (set_flags) flags_d = comb_status;
          end
        end
      end
      ST_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_free) begin
          result_d    = acc_q[WIDTH-1:0];
          status_d    = mul_status;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          if (setf_q) flags_d = mul_status;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      setf_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      setf_q      <= setf_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status    = status_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench: 8-bit instance for most scenarios, 64-bit instance for the wide ADD cases.
module tb_alu_pipe;

  typedef struct {
    logic [7:0] result;
    logic [3:0] status;
    logic       illegal;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       set_flags = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] status;
  logic [3:0] flags;
  logic       illegal;
  logic       busy;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [3:0]  op64 = '0;
  logic [63:0] a64 = '0;
  logic [63:0] b64 = '0;
  logic        cin64 = 1'b0;
  logic        out_valid64;
  logic [63:0] result64;
  logic [3:0]  status64;
  logic [3:0]  flags64;
  logic        illegal64;
  logic        busy64;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  alu_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .cin(cin), .set_flags(set_flags), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .status(status), .flags(flags),
    .illegal(illegal), .busy(busy)
  );

  alu_pipe #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .op(op64),
    .a(a64), .b(b64), .cin(cin64), .set_flags(1'b0), .out_valid(out_valid64),
    .out_ready(1'b1), .result(result64), .status(status64), .flags(flags64),
    .illegal(illegal64), .busy(busy64)
  );

  always #5 clk = ~clk;

  // Independent 8-bit reference written with integer arithmetic and bit loops.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                                 input logic xc);
    exp_t e;
    int ua = int'(xa);
    int ub = int'(xb);
    int sa = int'($signed(xa));
    int sb = int'($signed(xb));
    int sh = int'(xb[2:0]);
    int t;
    logic [7:0] r = '0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic il = 1'b0;
    case (o)
      4'd0: begin t = ua + ub + int'(xc); r = 8'(t); c = (t > 255);
                  t = sa + sb + int'(xc); v = (t > 127) || (t < -128); end
      4'd1: begin t = ua - ub; r = 8'(t); c = (ua >= ub);
                  t = sa - sb; v = (t > 127) || (t < -128); end
      4'd2: begin r = 8'(-ua); c = (ua == 0); v = (ua == 128); end
      4'd3: r = xa & xb;
      4'd4: r = xa | xb;
      4'd5: r = xa ^ xb;
      4'd6: r = ~xa;
      4'd7: r = xa;
      4'd8: begin r = xa; for (int i = 0; i < sh; i++) begin c = r[7]; r = {r[6:0], 1'b0}; end end
      4'd9: begin r = xa; for (int i = 0; i < sh; i++) begin c = r[0]; r = {1'b0, r[7:1]}; end end
      4'd10: begin r = xa; for (int i = 0; i < sh; i++) begin c = r[0]; r = {r[7], r[7:1]}; end end
      4'd11: begin t = ua * ub; r = 8'(t); v = (t > 255); end
      default: begin r = '0; il = 1'b1; end
    endcase
    e.result  = r;
    e.status  = {v, c, r[7], (r == 8'h00)};
    e.illegal = il;
    return e;
  endfunction

  // Output monitor: compares each consumed result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got result=%h status=%b with empty scoreboard", result, status);
      end else begin
        mon_e = sb_q.pop_front();
        if (result !== mon_e.result || status !== mon_e.status || illegal !== mon_e.illegal) begin
          miscompares++;
          $display("FAIL result_check: got r=%h st=%b il=%b, expected r=%h st=%b il=%b",
                   result, status, illegal, mon_e.result, mon_e.status, mon_e.illegal);
        end
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                      input logic xc, input logic xsf, input bit push);
    int n = 0;
    op = o; a = xa; b = xb; cin = xc; set_flags = xsf; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end else if (push) begin
      sb_q.push_back(model(o, xa, xb, xc));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || flags !== 4'h0 || result !== 8'h00 ||
        status !== 4'h0 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8: ov=%b busy=%b flags=%b r=%h st=%b il=%b, required all 0",
               out_valid, busy, flags, result, status, illegal);
    end
    vectors++;
    if (out_valid64 !== 1'b0 || result64 !== 64'h0 || status64 !== 4'h0 || flags64 !== 4'h0) begin
      miscompares++;
      $display("FAIL reset64: ov=%b r=%h st=%b flags=%b, required all 0",
               out_valid64, result64, status64, flags64);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || in_ready64 !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: in_ready=%b in_ready64=%b, required 1", in_ready, in_ready64);
    end
  endtask

  task automatic test_add64();
    logic [63:0] ta [3] = '{64'd3, 64'd0, {64{1'b1}}};
    logic [63:0] tb [3] = '{64'd1, 64'd0, 64'd1};
    logic [63:0] er [3] = '{64'd4, 64'd0, 64'd0};
    logic [3:0]  es [3] = '{4'b0000, 4'b0001, 4'b0101};
    for (int i = 0; i < 3; i++) begin
      op64 = 4'd0; a64 = ta[i]; b64 = tb[i]; cin64 = 1'b0; in_valid64 = 1'b1;
      @(posedge clk); #1;
      in_valid64 = 1'b0;
      vectors++;
      if (out_valid64 !== 1'b1 || result64 !== er[i] || status64 !== es[i]) begin
        miscompares++;
        $display("FAIL add64_%0d: ov=%b r=%h st=%b, required ov=1 r=%h st=%b",
                 i, out_valid64, result64, status64, er[i], es[i]);
      end
    end
  endtask

  task automatic test_flags();
    send(4'd1, 8'd2, 8'd4, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (flags !== 4'b0010) begin
      miscompares++;
      $display("FAIL flags_set: flags=%b, required 0010", flags);
    end
    send(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (flags !== 4'b0010) begin
      miscompares++;
      $display("FAIL flags_hold: flags=%b, required 0010", flags);
    end
    drain();
  endtask

  task automatic test_shift();
    send(4'd8, 8'h97, 8'd3, 1'b0, 1'b0, 1'b1);
    send(4'd10, 8'h97, 8'd3, 1'b0, 1'b0, 1'b1);
    send(4'd9, 8'h97, 8'd3, 1'b0, 1'b0, 1'b1);
    send(4'd8, 8'h97, 8'd0, 1'b0, 1'b0, 1'b1);
    send(4'd9, 8'h01, 8'd1, 1'b0, 1'b0, 1'b1);
    send(4'd10, 8'h80, 8'd7, 1'b0, 1'b0, 1'b1);
    send(4'd2, 8'h80, 8'd0, 1'b0, 1'b0, 1'b1);
    send(4'd2, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_mul();
    int  cyc = 0;
    bit  ok = 1'b1;
    send(4'd11, 8'd20, 8'd13, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (!ok || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_busy_window: busy/in_ready wrong during multiply, busy at end=%b required 0", busy);
    end
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    vectors++;
    if (cyc != 9) begin
      miscompares++;
      $display("FAIL mul_latency: %0d cycles, required 9", cyc);
    end
    vectors++;
    if (flags !== 4'b1000) begin
      miscompares++;
      $display("FAIL mul_flags: flags=%b, required 1000", flags);
    end
    drain();
    send(4'd11, 8'd7, 8'd6, 1'b0, 1'b0, 1'b1);
    drain();
    vectors++;
    if (flags !== 4'b1000) begin
      miscompares++;
      $display("FAIL mul_flags_hold: flags=%b, required 1000", flags);
    end
  endtask

  task automatic test_backpressure();
    bit ok = 1'b1;
    out_ready = 1'b0;
    send(4'd0, 8'd10, 8'd20, 1'b0, 1'b0, 1'b1);
    op = 4'd0; a = 8'd1; b = 8'd2; cin = 1'b0; set_flags = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 8'd30 || status !== 4'b0000 || in_ready !== 1'b0) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_stable: ov=%b r=%h st=%b in_ready=%b, required 1/1e/0000/0",
               out_valid, result, status, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_on_release: in_ready=%b, required 1", in_ready);
    end else begin
      sb_q.push_back(model(4'd0, 8'd1, 8'd2, 1'b0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || result !== 8'd3) begin
      miscompares++;
      $display("FAIL back_to_back_load: ov=%b r=%h, required 1/03", out_valid, result);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL no_duplicate: ov=%b pending=%0d, required 0/0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    send(4'd14, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b1);
    send(4'd12, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    send(4'd15, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 10)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    send(4'd11, 8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || flags !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid_mul: ov=%b busy=%b flags=%b, required 0/0/0000", out_valid, busy, flags);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(4'd0, 8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abandoned_mul: ov=%b, required 0 (no result from aborted multiply)", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add64();
    test_flags();
    test_shift();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
